// File: rtl/etroc2_ro_pkg.sv
// ---------------------------------------------------------------------------
// etroc2_ro_pkg
// Shared constants and types for the ETROC2 global-readout column arbiter.
//   NCOL   : number of pixel-array columns feeding the readout
//   CDW    : width of one column data word
//   COLIDW : width of the column index carried in each output word
//   OUTW   : output word width, {colID, colWord}
//   state_e: readout controller states
// ---------------------------------------------------------------------------
package etroc2_ro_pkg;

   localparam int NCOL   = 16;
   localparam int CDW    = 46;
   localparam int COLIDW = 4;
   localparam int OUTW   = CDW + COLIDW;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ARB  = 3'd1,
      S_READ = 3'd2,
      S_WAIT = 3'd3,
      S_OUT  = 3'd4,
      S_DONE = 3'd5
   } state_e;

endpackage

// File: rtl/rr_arbiter16.sv
// ---------------------------------------------------------------------------
// rr_arbiter16
// Combinational round-robin pick over 16 requests. Returns the index of the
// first set request at or after the pointer, wrapping 15 -> 0.
// Ports:
//   req_i   : per-column request vector
//   ptr_i   : search start position
//   grant_o : granted column index (meaningful only when any_o = 1)
//   any_o   : at least one request is set
// ---------------------------------------------------------------------------
module rr_arbiter16
   import etroc2_ro_pkg::*;
(
   input  logic [NCOL-1:0]   req_i,
   input  logic [COLIDW-1:0] ptr_i,
   output logic [COLIDW-1:0] grant_o,
   output logic              any_o
);

   // Rotating through a doubled vector puts column ptr_i at bit 0, so the
   // lowest set bit of req_rot is the distance from the pointer to the winner.
   logic [2*NCOL-2:0] req_dbl;
   logic [NCOL-1:0]   req_rot;
   logic [COLIDW-1:0] offset;

   assign req_dbl = {req_i[NCOL-2:0], req_i};
   assign req_rot = req_dbl[ptr_i +: NCOL];

   always_comb begin
      offset = '0;
      for (int i = NCOL - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            offset = COLIDW'(i);
         end
      end
   end

   // 4-bit addition wraps naturally modulo 16.
   assign grant_o = ptr_i + offset;
   assign any_o   = |req_i;

endmodule

// File: rtl/col_readout_arbiter.sv
// ---------------------------------------------------------------------------
// col_readout_arbiter
// Global-readout front end behind the 16-column pixel array. On each L1A it
// round-robin scans the column hit flags, strobes one column at a time,
// captures that column's word and emits {colID, word} on a valid/ready
// stream. Each event ends with a done pulse plus word count; words beyond
// MAXWORDS are still read out of the columns (drained) but not emitted.
// Ports:
//   clk, rstn    : clock, synchronous active-low reset
//   l1aStart     : one-cycle event start request
//   colHit       : per-column data-pending flags
//   colData      : 16 packed column words, column k at [CDW*k +: CDW]
//   colRead      : one-hot one-cycle column read strobe
//   dout         : {colID, colWord}
//   doutValid    : dout valid, held stable until doutReady
//   doutReady    : downstream accept
//   busy         : event in progress (accept through done cycle)
//   evtDone      : one-cycle end-of-event pulse
//   evtWordCnt   : words emitted in the last event, held until next event end
//   evtTrunc     : last event hit MAXWORDS and had data drained
//   l1aDropped   : one-cycle pulse, l1aStart seen while not idle
// ---------------------------------------------------------------------------
module col_readout_arbiter
   import etroc2_ro_pkg::*;
#(
   parameter int READLAT  = 1,
   parameter int MAXWORDS = 200,
   parameter int CNTW     = 8
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                l1aStart,
   input  logic [NCOL-1:0]     colHit,
   input  logic [NCOL*CDW-1:0] colData,
   output logic [NCOL-1:0]     colRead,
   output logic [OUTW-1:0]     dout,
   output logic                doutValid,
   input  logic                doutReady,
   output logic                busy,
   output logic                evtDone,
   output logic [CNTW-1:0]     evtWordCnt,
   output logic                evtTrunc,
   output logic                l1aDropped
);

   localparam logic [1:0]      WAIT_INIT = 2'(READLAT - 1);
   localparam logic [CNTW-1:0] MAXW_C    = CNTW'(MAXWORDS);

   state_e            state_q,     state_d;
   logic [COLIDW-1:0] ptr_q,       ptr_d;
   logic [COLIDW-1:0] grant_q,     grant_d;
   logic [CNTW-1:0]   count_q,     count_d;
   logic              trunc_q,     trunc_d;
   logic [1:0]        wait_q,      wait_d;
   logic [OUTW-1:0]   dout_q,      dout_d;
   logic [CNTW-1:0]   evt_cnt_q,   evt_cnt_d;
   logic              evt_trunc_q, evt_trunc_d;
   logic              drop_q,      drop_d;

   logic [COLIDW-1:0] arb_grant;
   logic              arb_any;
   logic [CDW-1:0]    col_word [NCOL];

   rr_arbiter16 u_rr (
      .req_i   (colHit),
      .ptr_i   (ptr_q),
      .grant_o (arb_grant),
      .any_o   (arb_any)
   );

   // Unpack the flat column bus and decode the read strobe per column.
   generate
      for (genvar gi = 0; gi < NCOL; gi++) begin : g_col
         assign col_word[gi] = colData[gi*CDW +: CDW];
         assign colRead[gi]  = (state_q == S_READ) && (grant_q == COLIDW'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         grant_q     <= '0;
         count_q     <= '0;
         trunc_q     <= 1'b0;
         wait_q      <= '0;
         dout_q      <= '0;
         evt_cnt_q   <= '0;
         evt_trunc_q <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         grant_q     <= grant_d;
         count_q     <= count_d;
         trunc_q     <= trunc_d;
         wait_q      <= wait_d;
         dout_q      <= dout_d;
         evt_cnt_q   <= evt_cnt_d;
         evt_trunc_q <= evt_trunc_d;
         drop_q      <= drop_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      grant_d     = grant_q;
      count_d     = count_q;
      trunc_d     = trunc_q;
      wait_d      = wait_q;
      dout_d      = dout_q;
      evt_cnt_d   = evt_cnt_q;
      evt_trunc_d = evt_trunc_q;
      // A start request is only honoured in IDLE; anywhere else it is flagged.
      drop_d      = l1aStart && (state_q != S_IDLE);

      unique case (state_q)
         S_IDLE: begin
            if (l1aStart) begin
               ptr_d   = '0;
               count_d = '0;
               trunc_d = 1'b0;
               state_d = S_ARB;
            end
         end
         S_ARB: begin
            if (!arb_any) begin
               evt_cnt_d   = count_q;
               evt_trunc_d = trunc_q;
               state_d     = S_DONE;
            end else begin
               grant_d = arb_grant;
               ptr_d   = arb_grant + COLIDW'(1);
               state_d = S_READ;
            end
         end
         S_READ: begin
            wait_d  = WAIT_INIT;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (wait_q != 2'd0) begin
               wait_d = wait_q - 2'd1;
            end else if (count_q < MAXW_C) begin
               dout_d  = {grant_q, col_word[grant_q]};
               state_d = S_OUT;
            end else begin
               // Over the limit: the column has already been strobed, so the
               // word is dropped here and the event is marked truncated.
               trunc_d = 1'b1;
               state_d = S_ARB;
            end
         end
         S_OUT: begin
            if (doutReady) begin
               count_d = count_q + CNTW'(1);
               state_d = S_ARB;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy       = (state_q != S_IDLE);
   assign doutValid  = (state_q == S_OUT);
   assign evtDone    = (state_q == S_DONE);
   assign dout       = dout_q;
   assign evtWordCnt = evt_cnt_q;
   assign evtTrunc   = evt_trunc_q;
   assign l1aDropped = drop_q;

endmodule

// File: tb/tb_col_readout_arbiter.sv
// ---------------------------------------------------------------------------
// tb_col_readout_arbiter
// Self-checking bench for col_readout_arbiter. The pixel columns are modelled
// as per-column word FIFOs that pop once a strobed read has been captured.
// At each event start the expected strobe order, emitted words, count and
// truncation flag are computed from the round-robin rules on a snapshot of
// those FIFOs, then compared against what the DUT does.
// ---------------------------------------------------------------------------
module tb_col_readout_arbiter;

   localparam int READLAT  = 1;
   localparam int MAXWORDS = 4;
   localparam int CNTW     = 8;
   localparam int BUDGET   = 400;

   logic          clk;
   logic          rstn;
   logic          l1aStart;
   logic [15:0]   colHit;
   logic [735:0]  colData;
   logic [15:0]   colRead;
   logic [49:0]   dout;
   logic          doutValid;
   logic          doutReady;
   logic          busy;
   logic          evtDone;
   logic [7:0]    evtWordCnt;
   logic          evtTrunc;
   logic          l1aDropped;

   int            checks;
   int            errors;

   // column model
   logic [45:0]   mem [16][8];
   int            depth [16];
   int            pend_cnt;
   int            pend_col;
   bit            garb;
   logic [15:0]   garb_hit;
   logic [31:0]   garb_w;

   // expectations for the current event
   int            exp_str [$];
   logic [49:0]   exp_out [$];
   int            exp_cnt;
   bit            exp_trunc;

   col_readout_arbiter #(
      .READLAT  (READLAT),
      .MAXWORDS (MAXWORDS),
      .CNTW     (CNTW)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .l1aStart   (l1aStart),
      .colHit     (colHit),
      .colData    (colData),
      .colRead    (colRead),
      .dout       (dout),
      .doutValid  (doutValid),
      .doutReady  (doutReady),
      .busy       (busy),
      .evtDone    (evtDone),
      .evtWordCnt (evtWordCnt),
      .evtTrunc   (evtTrunc),
      .l1aDropped (l1aDropped)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      colHit  = '0;
      colData = '0;
      if (garb) begin
         colHit  = garb_hit;
         colData = {23{garb_w}};
      end else begin
         for (int k = 0; k < 16; k++) begin
            colHit[k]           = (depth[k] != 0);
            colData[k*46 +: 46] = mem[k][0];
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic col_pop(input int c);
      for (int j = 0; j < 7; j++) mem[c][j] = mem[c][j+1];
      if (depth[c] > 0) depth[c]--;
   endtask

   task automatic put_word(input int c, input logic [45:0] w);
      if (depth[c] < 8) begin
         mem[c][depth[c]] = w;
         depth[c]++;
      end
   endtask

   task automatic clear_cols();
      for (int k = 0; k < 16; k++) begin
         depth[k] = 0;
         for (int j = 0; j < 8; j++) mem[k][j] = '0;
      end
   endtask

   // Advance to the next falling edge and update the column FIFOs: a
   // strobed column pops once the DUT has captured its word.
   task automatic step();
      @(negedge clk);
      if (!rstn) begin
         pend_cnt = 0;
      end else if (pend_cnt > 0) begin
         pend_cnt--;
         if (pend_cnt == 0) col_pop(pend_col);
      end
      if (colRead != 16'h0) begin
         for (int k = 0; k < 16; k++) if (colRead[k]) pend_col = k;
         pend_cnt = READLAT + 1;
      end
   endtask

   // Round-robin readout worked out directly on a copy of the column FIFOs.
   task automatic build_model();
      logic [45:0] m [16][8];
      int d [16];
      int ptr;
      int cnt;
      int g;
      bit tr;
      m = mem;
      d = depth;
      ptr = 0;
      cnt = 0;
      tr = 1'b0;
      exp_str.delete();
      exp_out.delete();
      forever begin
         g = -1;
         for (int i = 0; i < 16; i++) begin
            if (g < 0 && d[(ptr + i) % 16] > 0) g = (ptr + i) % 16;
         end
         if (g < 0) break;
         exp_str.push_back(g);
         if (cnt < MAXWORDS) begin
            exp_out.push_back({4'(g), m[g][0]});
            cnt++;
         end else begin
            tr = 1'b1;
         end
         for (int j = 0; j < 7; j++) m[g][j] = m[g][j+1];
         d[g]--;
         ptr = (g + 1) % 16;
      end
      exp_cnt   = cnt;
      exp_trunc = tr;
   endtask

   // rmode: 0 = random ready, 1 = always ready (after any initial stall)
   task automatic run_event(input string name, input int rmode, input int stall_n, input int drop_step);
      int          n;
      int          init_str;
      int          stall_left;
      int          idx;
      bit          done;
      bit          stalled;
      bit          prev_l1a;
      logic        rdy;
      logic [49:0] held;
      logic [15:0] oh;
      build_model();
      init_str   = exp_str.size();
      stall_left = stall_n;
      l1aStart   = 1'b1;
      doutReady  = 1'b0;
      prev_l1a   = 1'b1;
      stalled    = 1'b0;
      done       = 1'b0;
      held       = '0;
      n          = 0;
      while (!done) begin
         step();
         n++;
         if (n > BUDGET) begin
            checks++;
            errors++;
            $error("FAIL %s timeout: no evtDone within %0d cycles, required evtDone=1", name, BUDGET);
            break;
         end
         chk("l1a_dropped", 64'(l1aDropped), 64'(prev_l1a && n >= 2));
         l1aStart = (n == drop_step);
         prev_l1a = l1aStart;
         chk("busy", 64'(busy), 64'(1));
         if (stalled) begin
            chk("hold_valid", 64'(doutValid), 64'(1));
            chk("hold_dout", 64'(dout), 64'(held));
         end
         if (doutValid) chk("read_in_out", 64'(colRead), 64'(0));
         if (colRead != 16'h0) begin
            if (exp_str.size() == 0) begin
               chk("extra_strobe", 64'(colRead), 64'(0));
            end else begin
               idx = exp_str.pop_front();
               oh = '0;
               oh[idx] = 1'b1;
               chk("strobe", 64'(colRead), 64'(oh));
            end
         end
         if (evtDone) begin
            chk("evt_cnt", 64'(evtWordCnt), 64'(exp_cnt));
            chk("evt_trunc", 64'(evtTrunc), 64'(exp_trunc));
            chk("strobes_left", 64'(exp_str.size()), 64'(0));
            chk("words_left", 64'(exp_out.size()), 64'(0));
            if (init_str == 0) chk("empty_latency", 64'(n), 64'(2));
            done = 1'b1;
         end
         if (stall_left > 0) rdy = 1'b0;
         else if (rmode == 1) rdy = 1'b1;
         else rdy = 1'($urandom_range(0, 1));
         doutReady = rdy;
         if (doutValid) begin
            if (stall_left > 0) stall_left--;
            if (rdy) begin
               stalled = 1'b0;
               if (exp_out.size() == 0) chk("extra_word", 64'(dout), 64'(0));
               else chk("dout", 64'(dout), 64'(exp_out.pop_front()));
            end else begin
               stalled = 1'b1;
               held    = dout;
            end
         end else begin
            stalled = 1'b0;
         end
      end
      l1aStart = 1'b0;
      step();
      chk("post_dropped", 64'(l1aDropped), 64'(prev_l1a));
      chk("post_busy", 64'(busy), 64'(0));
      chk("post_done", 64'(evtDone), 64'(0));
      chk("post_cnt_held", 64'(evtWordCnt), 64'(exp_cnt));
      $display("event %s: strobes=%0d words=%0d trunc=%0d cycles=%0d", name, init_str, exp_cnt, exp_trunc, n);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_colRead"}, 64'(colRead), 64'(0));
      chk({tag, "_dout"}, 64'(dout), 64'(0));
      chk({tag, "_valid"}, 64'(doutValid), 64'(0));
      chk({tag, "_busy"}, 64'(busy), 64'(0));
      chk({tag, "_done"}, 64'(evtDone), 64'(0));
      chk({tag, "_cnt"}, 64'(evtWordCnt), 64'(0));
      chk({tag, "_trunc"}, 64'(evtTrunc), 64'(0));
      chk({tag, "_dropped"}, 64'(l1aDropped), 64'(0));
   endtask

   initial begin
      logic [63:0] r;
      int          total;
      checks    = 0;
      errors    = 0;
      pend_cnt  = 0;
      pend_col  = 0;
      garb      = 1'b1;
      garb_hit  = 16'hA5C3;
      garb_w    = 32'hDEADBEEF;
      rstn      = 1'b0;
      l1aStart  = 1'b1;
      doutReady = 1'b1;
      clear_cols();

      // 1: reset with garbage inputs, then idle with hits pending
      repeat (3) step();
      check_all_zero("reset");
      $display("reset applied with garbage inputs");
      garb     = 1'b0;
      l1aStart = 1'b0;
      put_word(7, 46'h0000_0BAD);
      rstn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("idle_no_strobe", 64'(colRead), 64'(0));
         chk("idle_busy", 64'(busy), 64'(0));
      end
      clear_cols();

      // 2: single hit on column 5
      put_word(5, 46'h1234);
      run_event("single_col5", 1, 0, -1);

      // 3: columns 3 (two words) and 12
      put_word(3, 46'h3_0000_0001);
      put_word(3, 46'h3_0000_0002);
      put_word(12, 46'hC_0000_0001);
      run_event("cols_3_12", 1, 0, -1);

      // empty event
      run_event("empty", 1, 0, -1);

      // 4: backpressure for 10 cycles on the first word
      put_word(10, 46'h2AAA_5555_1111);
      put_word(10, 46'h1555_AAAA_2222);
      run_event("backpressure", 1, 10, -1);

      // 5: column 0 with six words, limit of four
      for (int i = 0; i < 6; i++) put_word(0, 46'(64'h100 + i));
      run_event("truncate", 1, 0, -1);

      // 6a: l1aStart while busy
      put_word(9, 46'h9_0000_0009);
      put_word(9, 46'h9_0000_000A);
      run_event("mid_l1a", 1, 0, 3);

      // 6b: reset while a word is waiting in OUT
      clear_cols();
      for (int i = 0; i < 3; i++) put_word(9, 46'(64'h900 + i));
      doutReady = 1'b0;
      l1aStart  = 1'b1;
      step();
      l1aStart = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (doutValid) break;
         step();
      end
      chk("abort_valid", 64'(doutValid), 64'(1));
      rstn = 1'b0;
      step();
      step();
      check_all_zero("abort");
      rstn      = 1'b1;
      doutReady = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("abort_no_strobe", 64'(colRead), 64'(0));
         chk("abort_no_done", 64'(evtDone), 64'(0));
      end
      chk("abort_undrained", 64'(depth[9]), 64'(2));
      $display("reset mid-event applied");
      clear_cols();

      // randomized events
      for (int e = 0; e < 14; e++) begin
         for (int k = 0; k < 16; k++) begin
            if ($urandom_range(0, 3) == 0) begin
               for (int j = $urandom_range(1, 3); j > 0; j--) begin
                  r = {$urandom(), $urandom()};
                  put_word(k, r[45:0]);
               end
            end
         end
         run_event($sformatf("random_%0d", e), 0, $urandom_range(0, 3), ($urandom_range(0, 1) == 1) ? $urandom_range(2, 8) : -1);
         total = 0;
         for (int k = 0; k < 16; k++) total += depth[k];
         chk("drained", 64'(total), 64'(0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
